reflet_int_to_float_seq: RTL and testbench

Sequential converter from a two's-complement signed integer to a reflet floating-point word. It is the reverse of the float-to-int conversion path, for FPU operations such as `itof`. Normalization is iterative, one bit per cycle, which keeps area small for wide integers. It sits behind the FPU operand mux and uses a valid/ready handshake on both sides.

---
 rtl/reflet_int_to_float_seq_pkg.sv | 27 ++
 rtl/reflet_float_pack.sv | 28 ++
 rtl/reflet_int_to_float_seq.sv | 102 ++++++++++
 tb/tb_reflet_int_to_float_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/reflet_int_to_float_seq_pkg.sv
// Shared definitions for the sequential int-to-float converter:
// FSM state type and the reflet float field-size helpers.
package reflet_int_to_float_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } itof_state_t;

    function automatic int exponent_size(input int float_size);
        case (float_size)
            16:      return 5;
            64:      return 11;
            default: return 8;
        endcase
    endfunction

    function automatic int mantissa_size(input int float_size);
        return float_size - exponent_size(float_size) - 1;
    endfunction

    function automatic int exponent_bias(input int float_size);
        return (1 << (exponent_size(float_size) - 1)) - 1;
    endfunction

endpackage

// File: rtl/reflet_float_pack.sv
// Combinational packer: builds {sign, exp+bias, frac} from a normalized
// magnitude (hidden bit already stripped) and flags truncated bits.
module reflet_float_pack
    import reflet_int_to_float_seq_pkg::*;
#(
    parameter int frac_width = 15,
    parameter int float_size = 32
) (
    input  logic                                 sign,
    input  logic [exponent_size(float_size)-1:0] exp,
    input  logic [frac_width-1:0]                frac_bits,
    output logic [float_size-1:0]                float_out,
    output logic                                 inexact
);

    localparam int exp_w = exponent_size(float_size);
    localparam int man_w = mantissa_size(float_size);
    localparam logic [exp_w-1:0] bias = exp_w'(exponent_bias(float_size));

    // Appending man_w zeros lets one slice cover both the truncating and the
    // zero-padding case: the top man_w bits are the fraction, the rest is lost.
    logic [frac_width+man_w-1:0] aligned;

    assign aligned   = {frac_bits, {man_w{1'b0}}};
    assign float_out = {sign, exp + bias, aligned[frac_width+man_w-1 -: man_w]};
    assign inexact   = |aligned[frac_width-1:0];

endmodule

// File: rtl/reflet_int_to_float_seq.sv
// Sequential signed-integer to reflet float converter; normalizes the
// magnitude one bit per cycle behind a valid/ready handshake.
module reflet_int_to_float_seq
    import reflet_int_to_float_seq_pkg::*;
#(
    parameter int int_size   = 16,
    parameter int float_size = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [int_size-1:0]   int_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [float_size-1:0] float_out,
    output logic                  out_inexact
);

    localparam int exp_w = exponent_size(float_size);

    itof_state_t           state, state_next;
    logic                  sign, sign_next;
    logic [int_size-1:0]   mag, mag_next;
    logic [exp_w-1:0]      exp, exp_next;
    logic [float_size-1:0] float_next, packed_float;
    logic                  inexact_next, packed_inexact;

    reflet_float_pack #(
        .frac_width (int_size - 1),
        .float_size (float_size)
    ) u_pack (
        .sign      (sign),
        .exp       (exp),
        .frac_bits (mag[int_size-2:0]),
        .float_out (packed_float),
        .inexact   (packed_inexact)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sign        <= 1'b0;
            mag         <= '0;
            exp         <= '0;
            float_out   <= '0;
            out_inexact <= 1'b0;
        end else begin
            state       <= state_next;
            sign        <= sign_next;
            mag         <= mag_next;
            exp         <= exp_next;
            float_out   <= float_next;
            out_inexact <= inexact_next;
        end
    end

    // Negating the most negative value wraps to 100..0, which is exactly its
    // unsigned magnitude, so no extra width is needed.
    always_comb begin
        state_next   = state;
        sign_next    = sign;
        mag_next     = mag;
        exp_next     = exp;
        float_next   = float_out;
        inexact_next = out_inexact;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_next  = int_in[int_size-1];
                    mag_next   = int_in[int_size-1] ? -int_in : int_in;
                    exp_next   = exp_w'(int_size - 1);
                    state_next = NORM;
                end
            end
            NORM: begin
                if (mag == '0) begin
                    float_next   = '0;
                    inexact_next = 1'b0;
                    state_next   = DONE;
                end else if (mag[int_size-1]) begin
                    float_next   = packed_float;
                    inexact_next = packed_inexact;
                    state_next   = DONE;
                end else begin
                    mag_next = {mag[int_size-2:0], 1'b0};
                    exp_next = exp - exp_w'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reflet_int_to_float_seq.sv
// Directed bench for reflet_int_to_float_seq: a 16->32 instance and a 16->16
// instance, checked against hand-computed results and latencies.
module tb_reflet_int_to_float_seq;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        drv_valid;
    logic [15:0] drv_int;
    logic        out_ready;

    logic        in_valid_a, in_ready_a, out_valid_a, inexact_a;
    logic [31:0] float_a;
    logic        in_valid_b, in_ready_b, out_valid_b, inexact_b;
    logic [15:0] float_b;

    logic        cur_in_ready, cur_out_valid, cur_inexact;
    logic [63:0] cur_float;

    int n_checks;
    int n_pass;

    assign in_valid_a    = drv_valid && !sel;
    assign in_valid_b    = drv_valid && sel;
    assign cur_in_ready  = sel ? in_ready_b  : in_ready_a;
    assign cur_out_valid = sel ? out_valid_b : out_valid_a;
    assign cur_inexact   = sel ? inexact_b   : inexact_a;
    assign cur_float     = sel ? {48'b0, float_b} : {32'b0, float_a};

    reflet_int_to_float_seq #(.int_size(16), .float_size(32)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid_a),
        .in_ready    (in_ready_a),
        .int_in      (drv_int),
        .out_valid   (out_valid_a),
        .out_ready   (out_ready),
        .float_out   (float_a),
        .out_inexact (inexact_a)
    );

    reflet_int_to_float_seq #(.int_size(16), .float_size(16)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid_b),
        .in_ready    (in_ready_b),
        .int_in      (drv_int),
        .out_valid   (out_valid_b),
        .out_ready   (out_ready),
        .float_out   (float_b),
        .out_inexact (inexact_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        assert (obs === want) n_pass++;
        else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, want);
    endtask

    // Waits for the selected DUT to be idle, issues one request, then counts
    // edges after the accept edge until out_valid is seen at a falling edge.
    task automatic apply_stimulus(input logic use16, input logic [15:0] val,
                                  input logic [63:0] want_float, input logic want_inexact,
                                  input int want_lat, input string tag);
        int guard;
        int edges;
        sel   = use16;
        guard = 0;
        while (!cur_in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_output({tag, "_ready"}, 64'(cur_in_ready), 64'd1);
        drv_int   = val;
        drv_valid = 1'b1;
        @(posedge clk);
        #1 drv_valid = 1'b0;
        edges = 0;
        for (int n = 1; n <= 40 && edges == 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) check_output({tag, "_busy"}, 64'(cur_in_ready), 64'd0);
            if (cur_out_valid) edges = n;
        end
        check_output({tag, "_lat"}, 64'(edges), 64'(want_lat));
        check_output({tag, "_float"}, cur_float, want_float);
        check_output({tag, "_inexact"}, 64'(cur_inexact), 64'(want_inexact));
    endtask

    initial begin
        int edges;
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b0;
        sel       = 1'b0;
        drv_valid = 1'b0;
        drv_int   = '0;
        out_ready = 1'b1;

        @(negedge clk);
        check_output("rst_in_ready", 64'(in_ready_a), 64'd1);
        check_output("rst_out_valid", 64'(out_valid_a), 64'd0);
        check_output("rst_float", 64'(float_a), 64'd0);
        check_output("rst_inexact", 64'(inexact_a), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        apply_stimulus(1'b0, 16'd1,      64'h3F800000, 1'b0, 16, "one");
        apply_stimulus(1'b0, 16'hFFFF,   64'hBF800000, 1'b0, 16, "minus_one");
        apply_stimulus(1'b0, 16'd0,      64'h00000000, 1'b0, 1,  "zero");
        apply_stimulus(1'b0, 16'h8000,   64'hC7000000, 1'b0, 1,  "most_neg");
        apply_stimulus(1'b0, 16'd32767,  64'h46FFFE00, 1'b0, 2,  "most_pos");
        apply_stimulus(1'b0, 16'h8001,   64'hC6FFFE00, 1'b0, 2,  "neg_32767");
        apply_stimulus(1'b0, 16'd100,    64'h42C80000, 1'b0, 10, "hundred");
        apply_stimulus(1'b0, 16'd256,    64'h43800000, 1'b0, 8,  "pow2_256");
        apply_stimulus(1'b0, 16'hFFFB,   64'hC0A00000, 1'b0, 14, "minus_five");

        apply_stimulus(1'b1, 16'd2049,   64'h6800, 1'b1, 5,  "h_2049");
        apply_stimulus(1'b1, 16'd2048,   64'h6800, 1'b0, 5,  "h_2048");
        apply_stimulus(1'b1, 16'hF7FF,   64'hE800, 1'b1, 5,  "h_neg_2049");
        apply_stimulus(1'b1, 16'd1,      64'h3C00, 1'b0, 16, "h_one");
        apply_stimulus(1'b1, 16'd32767,  64'h77FF, 1'b1, 2,  "h_most_pos");

        // Backpressure: result must hold in DONE while a new request waits.
        out_ready = 1'b0;
        apply_stimulus(1'b0, 16'd1, 64'h3F800000, 1'b0, 16, "bp_one");
        drv_int   = 16'd5;
        drv_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("bp_hold_float", 64'(float_a), 64'h3F800000);
            check_output("bp_hold_in_ready", 64'(in_ready_a), 64'd0);
            check_output("bp_hold_out_valid", 64'(out_valid_a), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_output("bp_idle_in_ready", 64'(in_ready_a), 64'd1);
        check_output("bp_idle_out_valid", 64'(out_valid_a), 64'd0);
        @(negedge clk);
        check_output("bp_queued_accept", 64'(in_ready_a), 64'd0);
        drv_valid = 1'b0;
        edges = 0;
        for (int n = 1; n <= 40 && edges == 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid_a) edges = n;
        end
        check_output("bp_queued_lat", 64'(edges), 64'd14);
        check_output("bp_queued_float", 64'(float_a), 64'h40A00000);

        // Asynchronous reset in the middle of normalization.
        apply_stimulus(1'b0, 16'd256, 64'h43800000, 1'b0, 8, "pre_rst");
        @(negedge clk);
        drv_int   = 16'd1;
        drv_valid = 1'b1;
        @(posedge clk);
        #1 drv_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_output("arst_in_ready", 64'(in_ready_a), 64'd1);
        check_output("arst_out_valid", 64'(out_valid_a), 64'd0);
        check_output("arst_float", 64'(float_a), 64'd0);
        check_output("arst_inexact", 64'(inexact_a), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        apply_stimulus(1'b0, 16'd5, 64'h40A00000, 1'b0, 14, "post_rst_five");

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
